// File: rtl/adc_sequencer.sv
// SAR conversion sequencer: phase strobes, config latching and
// MSB-first decision capture for one adc_digital slice.
module adc_sequencer #(
  parameter int NBITS = 16,
  parameter int SAMPW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             abort,
  input  logic [SAMPW-1:0] samp_len,
  input  logic [4:0]       cfg_en,
  input  logic             cfg_dac_mode,
  input  logic             comp_out,
  output logic             seq_init,
  output logic             seq_samp,
  output logic             seq_comp,
  output logic             seq_update,
  output logic             en_init,
  output logic             en_samp_p,
  output logic             en_samp_n,
  output logic             en_comp,
  output logic             en_update,
  output logic             dac_mode,
  output logic             busy,
  output logic [NBITS-1:0] result,
  output logic             result_valid
);

  localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_SAMP,
    S_COMP,
    S_UPD,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [SAMPW-1:0] samp_cnt_q, samp_cnt_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic [NBITS-1:0] result_q, result_d;
  logic             cont_q, cont_d;
  logic [4:0]       en_q, en_d;
  logic             dac_q, dac_d;
  logic [3:0]       strb_q, strb_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [SAMPW-1:0] samp_ld;

  // SAMP counts down from max(samp_len,1)-1 to zero
  assign samp_ld = (samp_len == '0) ? '0
                 : samp_len - SAMPW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      samp_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      result_q   <= '0;
      cont_q     <= 1'b0;
      en_q       <= '0;
      dac_q      <= 1'b0;
      strb_q     <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      result_q   <= result_d;
      cont_q     <= cont_d;
      en_q       <= en_d;
      dac_q      <= dac_d;
      strb_q     <= strb_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start && !abort) state_d = S_INIT;
      S_INIT: state_d = S_SAMP;
      S_SAMP: if (samp_cnt_q == '0) state_d = S_COMP;
      S_COMP: state_d = S_UPD;
      S_UPD:  state_d = (bit_cnt_q < LAST) ? S_COMP : S_DONE;
      S_DONE: state_d = cont_q ? S_INIT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_comb begin
    samp_cnt_d = samp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    result_d   = result_q;
    cont_d     = cont_q;
    en_d       = en_q;
    dac_d      = dac_q;
    if (state_d == S_INIT) begin
      cont_d = cont;
      en_d   = cfg_en;
      dac_d  = cfg_dac_mode;
    end
    if (state_q == S_INIT) begin
      bit_cnt_d  = '0;
      shreg_d    = '0;
      samp_cnt_d = samp_ld;
    end
    if (state_q == S_SAMP && samp_cnt_q != '0)
      samp_cnt_d = samp_cnt_q - SAMPW'(1);
    if (state_q == S_COMP)
      shreg_d = NBITS'({shreg_q, comp_out});
    if (state_q == S_UPD && state_d == S_COMP)
      bit_cnt_d = bit_cnt_q + CW'(1);
    if (state_d == S_DONE)
      result_d = shreg_q;
    strb_d  = {state_d == S_INIT, state_d == S_SAMP,
               state_d == S_COMP, state_d == S_UPD};
    busy_d  = state_d != S_IDLE;
    valid_d = state_d == S_DONE;
  end

  assign {seq_init, seq_samp, seq_comp, seq_update} = strb_q;
  assign {en_init, en_samp_p, en_samp_n, en_comp, en_update} = en_q;
  assign dac_mode     = dac_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = valid_q;

endmodule
